// File: rtl/nischal_uart_tx.sv
// Byte-wide UART transmitter (8 data bits, LSB first, start/stop framing, fixed clock divide).
// Optional even parity bit after the data bits when UART_TX_PARITY_EN is defined.
module nischal_uart_tx #(
   parameter int CLKS_PER_BIT = 16,
   parameter int STOP_BITS    = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx,
   output logic       busy
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
   localparam logic STOP_LAST = 1'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_TX_PARITY_EN
      PARITY,
`endif
      STOP
   } state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [2:0]    bit_idx;
   logic          stop_idx;
   logic [7:0]    shift;
   logic          bit_end;
`ifdef UART_TX_PARITY_EN
   logic          parity;
`endif

   assign bit_end = (cnt == CNT_MAX);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         tx       <= 1'b1;
         tx_ready <= 1'b1;
         busy     <= 1'b0;
         cnt      <= '0;
         bit_idx  <= '0;
         stop_idx <= 1'b0;
         shift    <= '0;
`ifdef UART_TX_PARITY_EN
         parity   <= 1'b0;
`endif
      end else if (ena) begin
         // with ena low nothing advances, so a paused frame resumes exactly in place
         case (state)
            IDLE: begin
               if (tx_valid) begin
                  shift    <= tx_data;
`ifdef UART_TX_PARITY_EN
                  parity   <= ^tx_data;
`endif
                  state    <= START;
                  tx       <= 1'b0;
                  tx_ready <= 1'b0;
                  busy     <= 1'b1;
                  cnt      <= '0;
               end
            end
            START: begin
               if (bit_end) begin
                  cnt   <= '0;
                  state <= DATA;
                  tx    <= shift[0];
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DATA: begin
               if (bit_end) begin
                  cnt     <= '0;
                  bit_idx <= bit_idx + 1'b1;
                  if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                     state <= PARITY;
                     tx    <= parity;
`else
                     state    <= STOP;
                     tx       <= 1'b1;
                     stop_idx <= 1'b0;
`endif
                  end else begin
                     shift <= {1'b0, shift[7:1]};
                     tx    <= shift[1];
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
               if (bit_end) begin
                  cnt      <= '0;
                  state    <= STOP;
                  tx       <= 1'b1;
                  stop_idx <= 1'b0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
`endif
            STOP: begin
               if (bit_end) begin
                  cnt <= '0;
                  if (stop_idx == STOP_LAST) begin
                     state    <= IDLE;
                     tx_ready <= 1'b1;
                     busy     <= 1'b0;
                     stop_idx <= 1'b0;
                  end else begin
                     stop_idx <= stop_idx + 1'b1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state    <= IDLE;
               tx       <= 1'b1;
               tx_ready <= 1'b1;
               busy     <= 1'b0;
               cnt      <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_nischal_uart_tx.sv
// Directed bench for nischal_uart_tx at CLKS_PER_BIT=4, STOP_BITS=1.
// Honours UART_TX_PARITY_EN so the same bench covers both builds.
module tb_nischal_uart_tx;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ena = 1'b1;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready;
   logic       tx;
   logic       busy;

   int total = 0;
   int bad = 0;

`ifdef UART_TX_PARITY_EN
   localparam int FLEN = 44;
   localparam int NB   = 11;
`else
   localparam int FLEN = 40;
   localparam int NB   = 10;
`endif
   localparam int GAP = FLEN + 1;

   nischal_uart_tx #(.CLKS_PER_BIT(4), .STOP_BITS(1)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .ena      (ena),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .tx       (tx),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] data;
      logic [9:0] frame;   // bit0 = first bit on the wire: {stop, data, start}
      logic       par;
      int         pause_at;
      string      name;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [10:0] expect_bits(input logic [9:0] fr, input logic par);
`ifdef UART_TX_PARITY_EN
      return {1'b1, par, fr[8:0]};
`else
      return {1'b0, fr};
`endif
   endfunction

   task automatic run_frame(input logic [7:0] d, input logic [9:0] fr, input logic par,
                            input int pause_at, input string name);
      int          k, wall, pleft, n;
      logic        ena_prev, paused, hold, hold_bad, ready_bad;
      logic [10:0] got;
      k = 0; wall = 0; pleft = 0; n = 0;
      ena_prev = 1'b1; paused = 1'b0; hold = 1'b1; hold_bad = 1'b0; ready_bad = 1'b0;
      got = '0;
      while (tx_ready !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      tx_data  = d;
      tx_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      tx_valid = 1'b0;
      tx_data  = ~d;
      while (busy === 1'b1 && wall < 400) begin
         if (!ena_prev) begin
            if (tx !== hold) hold_bad = 1'b1;
         end else if (k % 4 == 2 && k / 4 <= 10) begin
            got[k/4] = tx;
         end
         if (tx_ready !== 1'b0) ready_bad = 1'b1;
         if (!ena) begin
            pleft--;
            if (pleft == 0) ena = 1'b1;
         end else if (!paused && k == pause_at) begin
            paused = 1'b1;
            ena    = 1'b0;
            hold   = tx;
            pleft  = 7;
         end
         ena_prev = ena;
         @(posedge clk);
         @(negedge clk);
         wall++;
         if (ena_prev) k++;
      end
      ena = 1'b1;
      chk({name, "_len"}, 32'(wall), 32'(FLEN + (pause_at >= 0 ? 7 : 0)));
      chk({name, "_bits"}, 32'(got[NB-1:0]), 32'(expect_bits(fr, par)));
      chk({name, "_ready_busy"}, 32'(ready_bad), 32'd0);
      chk({name, "_idle"}, {30'd0, tx, tx_ready}, 32'd3);
      if (pause_at >= 0) chk({name, "_hold"}, 32'(hold_bad), 32'd0);
   endtask

   logic wave[0:99];

   initial begin
      int          second_start;
      logic [10:0] f1, f2;

      vecs[0] = '{8'hA5, 10'h34A, 1'b0, -1, "a5"};
      vecs[1] = '{8'h07, 10'h20E, 1'b1, -1, "x07"};
      vecs[2] = '{8'h3C, 10'h278, 1'b0, 17, "pause3c"};
      vecs[3] = '{8'h01, 10'h202, 1'b1, -1, "x01"};
      vecs[4] = '{8'hFF, 10'h3FE, 1'b0, -1, "ff"};
      vecs[5] = '{8'h5A, 10'h2B4, 1'b0, -1, "x5a"};

      // reset with a pending request: reset must win
      rst_n = 1'b0; ena = 1'b1; tx_valid = 1'b1; tx_data = 8'hAA;
      repeat (3) @(posedge clk);
      @(negedge clk);
      tx_valid = 1'b0;
      chk("rst_tx", 32'(tx), 32'd1);
      chk("rst_ready", 32'(tx_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_tx", 32'(tx), 32'd1);

      for (int i = 0; i < 6; i++)
         run_frame(vecs[i].data, vecs[i].frame, vecs[i].par, vecs[i].pause_at, vecs[i].name);

      // back-to-back with tx_valid held high; tx_data changes after the first handshake
      @(negedge clk);
      tx_data  = 8'h00;
      tx_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      tx_data = 8'hFF;
      for (int k = 0; k < 100; k++) begin
         wave[k] = tx;
         if (k == GAP) tx_valid = 1'b0;
         @(posedge clk);
         @(negedge clk);
      end
      second_start = -1;
      for (int k = 36; k < 100; k++)
         if (second_start < 0 && wave[k-1] == 1'b1 && wave[k] == 1'b0) second_start = k;
      chk("b2b_gap", 32'(second_start), 32'(GAP));
      f1 = '0; f2 = '0;
      for (int i = 0; i < NB; i++) begin
         f1[i] = wave[4*i+2];
         f2[i] = wave[GAP+4*i+2];
      end
      chk("b2b_first", 32'(f1), 32'(expect_bits(10'h200, 1'b0)));
      chk("b2b_second", 32'(f2), 32'(expect_bits(10'h3FE, 1'b0)));
      chk("b2b_idle", {30'd0, tx, busy}, 32'd2);

      // abort during data bit 5 of 0x00
      @(negedge clk);
      tx_data  = 8'h00;
      tx_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      tx_valid = 1'b0;
      repeat (25) @(negedge clk);
      chk("abort_pre", {30'd0, tx, busy}, 32'd1);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("abort_tx", 32'(tx), 32'd1);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_ready", 32'(tx_ready), 32'd1);
      rst_n = 1'b1;
      run_frame(8'h81, 10'h302, 1'b0, -1, "after_abort");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
